// File: rtl/ns_mode_controller.sv
// Mode sequencer for the fifth-order noise-shaping modulator: start-up clear/settle,
// HDR/HSNR gain-mode switching with hysteresis, safe gain updates and run-length overload recovery.
module ns_mode_controller #(
  parameter int LEVEL_W       = 23,
  parameter int GAIN_W        = 24,
  parameter int HYST_CNT      = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int RUN_LIMIT     = 32
) (
  input  logic                      CLK_3M,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [LEVEL_W-1:0] data_i,
  input  logic                      ns_bit,
  input  logic        [LEVEL_W-2:0] cfg_thresh_hi,
  input  logic        [LEVEL_W-2:0] cfg_thresh_lo,
  input  logic signed [GAIN_W-1:0]  cfg_gain_pos,
  input  logic signed [GAIN_W-1:0]  cfg_gain_neg,
  input  logic                      cfg_load,
  output logic                      ns_enable,
  output logic                      ns_alpha,
  output logic signed [GAIN_W-1:0]  ns_gain_pos,
  output logic signed [GAIN_W-1:0]  ns_gain_neg,
  output logic                      ns_clear,
  output logic                      overload_flag,
  output logic        [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    SETTLE   = 3'd2,
    RUN_HDR  = 3'd3,
    RUN_HSNR = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int LOW_W = $clog2(HYST_CNT + 1);
  localparam int RUN_W = $clog2(RUN_LIMIT + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOW_W-1:0] LOW_LAST    = LOW_W'(HYST_CNT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(RUN_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

  state_t             state, state_nxt;
  logic               alpha_nxt, enable_nxt, clear_nxt, flag_nxt;
  logic [SET_W-1:0]   settle_cnt, settle_nxt;
  logic [LOW_W-1:0]   low_cnt, low_nxt;
  logic [RUN_W-1:0]   run_cnt, run_nxt, run_inc;
  logic               prev_bit, unstable;
  logic signed [GAIN_W-1:0] pend_pos, pend_neg;
  logic               pend_valid, hold_gains, copy_en;
  logic [LEVEL_W-1:0] abs_full;
  logic [LEVEL_W-2:0] mag;

  // The most negative sample has no positive twin; it is clamped to full scale.
  assign abs_full = data_i[LEVEL_W-1] ? -data_i : data_i;
  assign mag      = abs_full[LEVEL_W-1] ? '1 : abs_full[LEVEL_W-2:0];

  assign run_inc  = (run_cnt != '0 && ns_bit == prev_bit)
                    ? ((run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1)
                    : RUN_ONE;
  assign unstable = (run_inc == RUN_MAX);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    alpha_nxt  = ns_alpha;
    flag_nxt   = overload_flag;
    settle_nxt = settle_cnt;
    low_nxt    = low_cnt;
    run_nxt    = run_cnt;
    if (!start) begin
      state_nxt  = IDLE;
      alpha_nxt  = 1'b0;
      flag_nxt   = 1'b0;
      settle_nxt = '0;
      low_nxt    = '0;
      run_nxt    = '0;
    end else begin
      unique case (state)
        IDLE: state_nxt = CLEAR;
        CLEAR: begin
          state_nxt  = SETTLE;
          alpha_nxt  = 1'b0;
          settle_nxt = '0;
        end
        SETTLE: begin
          if (settle_cnt >= SETTLE_LAST) begin
            state_nxt  = ns_alpha ? RUN_HSNR : RUN_HDR;
            settle_nxt = '0;
            low_nxt    = '0;
            run_nxt    = '0;
          end else begin
            settle_nxt = settle_cnt + 1'b1;
          end
        end
        RUN_HDR: begin
          run_nxt = run_inc;
          if (unstable) begin
            state_nxt = RECOVER;
            alpha_nxt = 1'b0;
            flag_nxt  = 1'b1;
            low_nxt   = '0;
            run_nxt   = '0;
          end else if (mag < cfg_thresh_lo) begin
            if (low_cnt >= LOW_LAST) begin
              state_nxt  = SETTLE;
              alpha_nxt  = 1'b1;
              settle_nxt = '0;
              low_nxt    = '0;
              run_nxt    = '0;
            end else begin
              low_nxt = low_cnt + 1'b1;
            end
          end else begin
            low_nxt = '0;
          end
        end
        RUN_HSNR: begin
          run_nxt = run_inc;
          if (unstable) begin
            state_nxt = RECOVER;
            alpha_nxt = 1'b0;
            flag_nxt  = 1'b1;
            low_nxt   = '0;
            run_nxt   = '0;
          end else if (mag >= cfg_thresh_hi) begin
            state_nxt  = SETTLE;
            alpha_nxt  = 1'b0;
            settle_nxt = '0;
            low_nxt    = '0;
            run_nxt    = '0;
          end
        end
        RECOVER: begin
          state_nxt = CLEAR;
          alpha_nxt = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          alpha_nxt = 1'b0;
        end
      endcase
    end
    enable_nxt = (state_nxt == SETTLE) || (state_nxt == RUN_HDR) || (state_nxt == RUN_HSNR);
    clear_nxt  = (state_nxt == CLEAR);
  end

  // Gains may only change while the HSNR loop is not using them; a coincident load bypasses pending.
  assign hold_gains = (state == RUN_HSNR && state_nxt == RUN_HSNR) || (state == SETTLE && ns_alpha);
  assign copy_en    = !hold_gains && (pend_valid || cfg_load);

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK_3M) begin
    if (reset) begin
      state         <= IDLE;
      ns_enable     <= 1'b0;
      ns_alpha      <= 1'b0;
      ns_clear      <= 1'b0;
      overload_flag <= 1'b0;
      ns_gain_pos   <= '0;
      ns_gain_neg   <= '0;
      settle_cnt    <= '0;
      low_cnt       <= '0;
      run_cnt       <= '0;
      prev_bit      <= 1'b0;
      pend_pos      <= '0;
      pend_neg      <= '0;
      pend_valid    <= 1'b0;
    end else begin
      state         <= state_nxt;
      ns_enable     <= enable_nxt;
      ns_alpha      <= alpha_nxt;
      ns_clear      <= clear_nxt;
      overload_flag <= flag_nxt;
      settle_cnt    <= settle_nxt;
      low_cnt       <= low_nxt;
      run_cnt       <= run_nxt;
      prev_bit      <= ns_bit;
      if (cfg_load) begin
        pend_pos <= cfg_gain_pos;
        pend_neg <= cfg_gain_neg;
      end
      if (copy_en) begin
        ns_gain_pos <= cfg_load ? cfg_gain_pos : pend_pos;
        ns_gain_neg <= cfg_load ? cfg_gain_neg : pend_neg;
      end
      if (cfg_load)     pend_valid <= !copy_en;
      else if (copy_en) pend_valid <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_ns_mode_controller.sv
// Scoreboard bench for ns_mode_controller: directed stimulus queues expected output vectors
// tagged with a cycle number; a monitor compares them on the falling edge.
module tb_ns_mode_controller;

  localparam int LEVEL_W = 23;
  localparam int GAIN_W  = 24;

  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_SETTLE = 3'd2,
                         S_HDR  = 3'd3, S_HSNR  = 3'd4, S_RECOVER = 3'd5;

  typedef logic [54:0] obs_t;
  typedef struct {
    int    cyc;
    string name;
    obs_t  obs;
  } exp_t;

  logic CLK_3M = 1'b0;
  logic reset = 1'b1, start = 1'b0, ns_bit = 1'b0, cfg_load = 1'b0;
  logic signed [LEVEL_W-1:0] data_i = '0;
  logic [LEVEL_W-2:0] cfg_thresh_hi = 22'd2097152;
  logic [LEVEL_W-2:0] cfg_thresh_lo = 22'd1000;
  logic signed [GAIN_W-1:0] cfg_gain_pos = '0, cfg_gain_neg = '0;
  logic ns_enable, ns_alpha, ns_clear, overload_flag;
  logic signed [GAIN_W-1:0] ns_gain_pos, ns_gain_neg;
  logic [2:0] state_o;

  ns_mode_controller dut (
    .CLK_3M        (CLK_3M),
    .reset         (reset),
    .start         (start),
    .data_i        (data_i),
    .ns_bit        (ns_bit),
    .cfg_thresh_hi (cfg_thresh_hi),
    .cfg_thresh_lo (cfg_thresh_lo),
    .cfg_gain_pos  (cfg_gain_pos),
    .cfg_gain_neg  (cfg_gain_neg),
    .cfg_load      (cfg_load),
    .ns_enable     (ns_enable),
    .ns_alpha      (ns_alpha),
    .ns_gain_pos   (ns_gain_pos),
    .ns_gain_neg   (ns_gain_neg),
    .ns_clear      (ns_clear),
    .overload_flag (overload_flag),
    .state_o       (state_o)
  );

  always #5 CLK_3M = ~CLK_3M;

  int cyc = 0;
  always @(posedge CLK_3M) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic tog = 1'b1;
  logic [GAIN_W-1:0] gpos_e = '0, gneg_e = '0;
  obs_t obs;

  assign obs = {state_o, ns_enable, ns_alpha, ns_clear, overload_flag, ns_gain_pos, ns_gain_neg};

  // Expected vector {state, enable, alpha, clear, overload, gain_pos, gain_neg}.
  function automatic obs_t mk(logic [2:0] st, logic en, logic al, logic cl, logic fl);
    return {st, en, al, cl, fl, gpos_e, gneg_e};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got st=%0d en=%b al=%b clr=%b ovf=%b gp=%h gn=%h, expected st=%0d en=%b al=%b clr=%b ovf=%b gp=%h gn=%h",
               name, cyc, act[54:52], act[51], act[50], act[49], act[48], act[47:24], act[23:0],
               exp[54:52], exp[51], exp[50], exp[49], exp[48], exp[47:24], exp[23:0]);
    end
  endtask

  task automatic expect_at(input int c, input string name, input obs_t o);
    exp_t e;
    e.cyc  = c;
    e.name = name;
    e.obs  = o;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK_3M);
    #1;
    if (tog) ns_bit = ~ns_bit;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK_3M);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: due at cycle %0d, never sampled (now %0d)", e.name, e.cyc, cyc);
        end else begin
          check(e.name, obs, e.obs);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7;

    tick();
    tick();
    expect_at(cyc, "reset_state", mk(S_IDLE, 0, 0, 0, 0));
    reset = 1'b0;
    tick();

    // Start-up: clear pulse, 16 settle cycles, 64 quiet cycles then HSNR.
    t0 = cyc;
    start = 1'b1;
    expect_at(t0 + 1,  "clear_pulse",      mk(S_CLEAR,  0, 0, 1, 0));
    expect_at(t0 + 2,  "settle_enable",    mk(S_SETTLE, 1, 0, 0, 0));
    expect_at(t0 + 17, "settle_last",      mk(S_SETTLE, 1, 0, 0, 0));
    expect_at(t0 + 18, "run_hdr",          mk(S_HDR,    1, 0, 0, 0));
    expect_at(t0 + 81, "hdr_before_hyst",  mk(S_HDR,    1, 0, 0, 0));
    expect_at(t0 + 82, "hyst_to_hsnr",     mk(S_SETTLE, 1, 1, 0, 0));
    expect_at(t0 + 98, "run_hsnr",         mk(S_HSNR,   1, 1, 0, 0));
    run_to(t0 + 100);

    // Gain load while in HSNR is held until alpha falls on a saturating sample.
    t1 = cyc;
    cfg_gain_pos = 24'h100000;
    cfg_gain_neg = 24'hFFFFFB;
    cfg_load = 1'b1;
    expect_at(t1 + 1, "hsnr_load_held", mk(S_HSNR, 1, 1, 0, 0));
    tick();
    cfg_load = 1'b0;
    run_to(t1 + 3);
    t2 = cyc;
    expect_at(t2, "hsnr_gain_still_held", mk(S_HSNR, 1, 1, 0, 0));
    data_i = 23'h400000;
    gpos_e = 24'h100000;
    gneg_e = 24'hFFFFFB;
    expect_at(t2 + 1, "fast_attack_saturated", mk(S_SETTLE, 1, 0, 0, 0));
    tick();
    data_i = 23'd5000;
    expect_at(t2 + 17, "settle_to_hdr", mk(S_HDR, 1, 0, 0, 0));
    run_to(t2 + 17);

    // 63 quiet cycles alternating with 63 loud ones never reach the hysteresis count.
    t3 = cyc;
    expect_at(t3 + 63, "hdr_low_63",    mk(S_HDR, 1, 0, 0, 0));
    expect_at(t3 + 64, "hdr_no_switch", mk(S_HDR, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      data_i = '0;
      repeat (63) tick();
      data_i = 23'd5000;
      repeat (63) tick();
    end
    t4 = cyc;
    expect_at(t4, "hdr_after_toggling", mk(S_HDR, 1, 0, 0, 0));
    cfg_gain_pos = 24'h000123;
    cfg_gain_neg = 24'h000456;
    cfg_load = 1'b1;
    gpos_e = 24'h000123;
    gneg_e = 24'h000456;
    expect_at(t4 + 1, "hdr_load_immediate", mk(S_HDR, 1, 0, 0, 0));
    tick();
    cfg_load = 1'b0;

    // Stuck modulator bit: 32 identical bits trip recovery; a stuck bit while settling does not.
    tog = 1'b0;
    ns_bit = 1'b0;
    tick();
    t5 = cyc;
    ns_bit = 1'b1;
    expect_at(t5 + 31, "run_31_no_trip",   mk(S_HDR,     1, 0, 0, 0));
    expect_at(t5 + 32, "run_limit_trip",   mk(S_RECOVER, 0, 0, 0, 1));
    expect_at(t5 + 33, "recover_clear",    mk(S_CLEAR,   0, 0, 1, 1));
    expect_at(t5 + 34, "recover_settle",   mk(S_SETTLE,  1, 0, 0, 1));
    expect_at(t5 + 49, "settle_masks_run", mk(S_SETTLE,  1, 0, 0, 1));
    expect_at(t5 + 50, "back_to_hdr",      mk(S_HDR,     1, 0, 0, 1));
    run_to(t5 + 50);
    tog = 1'b1;
    expect_at(t5 + 85, "overload_sticky",  mk(S_HDR,     1, 0, 0, 1));
    run_to(t5 + 85);

    // Stop while settling into HSNR clears everything except the applied gains.
    t6 = cyc;
    data_i = '0;
    expect_at(t6 + 63, "hdr_low_63_again", mk(S_HDR,    1, 0, 0, 1));
    expect_at(t6 + 64, "hyst_switch",      mk(S_SETTLE, 1, 1, 0, 1));
    expect_at(t6 + 66, "settle_hsnr",      mk(S_SETTLE, 1, 1, 0, 1));
    run_to(t6 + 66);
    start = 1'b0;
    expect_at(t6 + 67, "stop_in_settle",   mk(S_IDLE,   0, 0, 0, 0));
    tick();
    tick();

    // Reset in HSNR returns every output, gains included, to zero; restart needs start seen again.
    t7 = cyc;
    start = 1'b1;
    expect_at(t7 + 1,  "restart_clear", mk(S_CLEAR,  0, 0, 1, 0));
    expect_at(t7 + 18, "restart_hdr",   mk(S_HDR,    1, 0, 0, 0));
    expect_at(t7 + 82, "restart_hyst",  mk(S_SETTLE, 1, 1, 0, 0));
    expect_at(t7 + 98, "restart_hsnr",  mk(S_HSNR,   1, 1, 0, 0));
    run_to(t7 + 100);
    reset = 1'b1;
    gpos_e = '0;
    gneg_e = '0;
    expect_at(t7 + 101, "reset_in_hsnr", mk(S_IDLE, 0, 0, 0, 0));
    tick();
    expect_at(t7 + 102, "reset_held",    mk(S_IDLE, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    expect_at(t7 + 103, "start_after_reset", mk(S_CLEAR, 0, 0, 1, 0));
    tick();
    start = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    while (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
